ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the five-stage MIPS pipeline. It sits directly downstream of the ID/EX register and consumes its EX_* outputs. It forwards operands from MEM and WB, selects ALU sources, and evaluates the 6-bit ALUFun operation. It then registers the result, store data and write-back controls into the EX/MEM pipeline register feeding the data-memory stage.

## Interface
Parameters:
- RESET_PC, 32'h8000_0000, reset value of MEM_PC.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-low reset.
- EX_ALUFun  in  6  ALU operation.
- EX_Sign  in  1  signed compare select.
- EX_ALUSrc1, EX_ALUSrc2  in  1 each  operand selects.
- EX_EXTOp, EX_LUOp  in  1 each  immediate sign-extend and upper-immediate selects.
- EX_dataA, EX_dataB  in  32 each  register operands.
- EX_imm  in  16  immediate.
- EX_shamt  in  5  shift amount.
- EX_rs, EX_rt, EX_WrReg  in  5 each  source and destination register numbers.
- EX_RegWr, EX_MemWr, EX_MemRd  in  1 each  controls.
- EX_MemtoReg  in  2  write-back select.
- EXcontrol_jal  in  1  link instruction.
- EX_PC  in  32  instruction PC.
- WB_RegWr  in  1  WB write enable.
- WB_WrReg  in  5  WB destination register.
- WB_data  in  32  WB write data.
- MEM_ALUOut, MEM_dataB, MEM_PC  out  32 each  registered results.
- MEM_WrReg  out  5  registered destination.
- MEM_RegWr, MEM_MemWr, MEM_MemRd  out  1 each  registered controls.
- MEM_MemtoReg  out  2  registered write-back select.
- ex_stall  out  1  hold request to IF/ID and ID/EX.

## Operation
- Forwarding for A (EX_rs) and for B (EX_rt):
  - MEM stage has priority: when MEM_RegWr is high and MEM_WrReg equals the source register, the operand is MEM_ALUOut.
  - Otherwise WB: when WB_RegWr is high and WB_WrReg equals the source register, the operand is WB_data.
  - Otherwise the operand is EX_dataA or EX_dataB.
  - Register 0 is never forwarded.
- Forwarded B is the store data.
- Immediate: imm32 = EX_LUOp ? {imm,16'h0} : (EX_EXTOp ? sign-extend : zero-extend).
- Operand A = EX_ALUSrc1 ? {27'b0,EX_shamt} : fwdA.
- Operand B = EX_ALUSrc2 ? imm32 : fwdB.
- ALUFun encoding:
  - Add/subtract: 000000 ADD, 000001 SUB.
  - Logic: 011000 AND, 011110 OR, 010110 XOR, 010001 NOR, 011010 pass A.
  - Shifts: 100000 SLL, 100001 SRL, 100011 SRA. B is shifted by A[4:0].
  - Compares: 110011 EQ, 110001 NE, 110101 LT, 111101 LEZ, 111011 LTZ, 111111 GEZ-false/GTZ.
  - Compare results are 32-bit 0 or 1. LT is signed when EX_Sign=1, else unsigned.
  - Undefined codes yield 0.
- Result select: the result is EX_PC+4 when EXcontrol_jal=1, else the ALU output. All arithmetic is 32-bit wraparound with no overflow trap.

## Timing
- Single-cycle operations are registered on the rising clk edge, giving 1-cycle latency from EX inputs to MEM outputs.
- Reset values (while reset is low):
  - All MEM_* data outputs and MEM_WrReg are 0.
  - MEM_PC = RESET_PC.
  - All MEM_* controls are 0.
  - ex_stall = 0.
  - FSM is in IDLE.
- Reset asserted mid-multiply aborts the operation. No MEM write is issued.
- During a stall, the EX/MEM register captures a bubble: RegWr, MemWr and MemRd are 0, and data is don't-care but held.
- Forwarding is evaluated every cycle from the current MEM and WB values.

## Configuration
- EX_MUL_EN defined: adds ALUFun 000100 MUL, which returns the low 32 bits of the unsigned A×B product via a multi-cycle unit.
  - The MUL enters EX in cycle n.
  - Operands are latched at the end of cycle n.
  - FSM sequence: IDLE→BUSY (32 shift-add iterations)→DONE→IDLE.
  - ex_stall is high in cycles n..n+32 and low in n+33.
  - The EX/MEM register captures the product at the end of n+33.
  - Back-to-back MULs restart from IDLE.
- EX_MUL_EN undefined: there is no FSM and ex_stall is tied to 0. Code 000100 decodes as ADD.

## Structure
- Shared package ex_pkg holds:
  - the ALUFun localparams;
  - the FSM state enum (IDLE, BUSY, DONE);
  - the width constants.
- Sub-module alu (combinational ALUFun evaluator) is instantiated once.
- The multiplier FSM stays inline in ex_stage under EX_MUL_EN.

## Test plan
- Reset: hold reset low, then release. Required: MEM_PC=32'h80000000, all controls 0, ex_stall=0.
- ADD with MEM forward: EX_rs=5, MEM_WrReg=5, MEM_RegWr=1, MEM_ALUOut=7, WB also targets 5 with WB_data=9, fwdB=3. Required: MEM_ALUOut=10 next cycle.
- $0 guard: EX_rs=0, MEM_WrReg=0, MEM_RegWr=1, MEM_ALUOut=0xFFFF_FFFF. Required: operand A is EX_dataA.
- Compare and shift:
  - LT with A=0xFFFF_FFFF, B=1 gives 1 when EX_Sign=1 and 0 when EX_Sign=0.
  - SRA with shamt 4 on 0x8000_0000 gives 0xF800_0000.
- jal: EXcontrol_jal=1, EX_PC=0x0040_0010. Required: MEM_ALUOut=0x0040_0014, MEM_WrReg=EX_WrReg.
- EX_MUL_EN: MUL 0x0001_0003 × 0x0000_0005. Required:
  - ex_stall high for exactly 33 cycles with bubbles in MEM_*.
  - Result MEM_ALUOut=0x0005_000F.
  - A reset mid-BUSY returns the FSM to IDLE and produces no write.

Source files
------------

// File: rtl/ex_pkg.sv
// ex_pkg: shared constants for the execute stage.
//   - datapath / register-number / function-code widths
//   - ALUFun operation codes
//   - multiplier FSM state type (used only when EX_MUL_EN is defined)
package ex_pkg;

    localparam int unsigned DataW = 32;
    localparam int unsigned RegW  = 5;
    localparam int unsigned FunW  = 6;
    localparam int unsigned ImmW  = 16;
    localparam int unsigned MulIters = 32;

    // Add / subtract
    localparam logic [FunW-1:0] AluAdd  = 6'b000000;
    localparam logic [FunW-1:0] AluSub  = 6'b000001;
    // Multi-cycle multiply (EX_MUL_EN); aliases ADD when the unit is absent
    localparam logic [FunW-1:0] AluMul  = 6'b000100;
    // Logic
    localparam logic [FunW-1:0] AluAnd  = 6'b011000;
    localparam logic [FunW-1:0] AluOr   = 6'b011110;
    localparam logic [FunW-1:0] AluXor  = 6'b010110;
    localparam logic [FunW-1:0] AluNor  = 6'b010001;
    localparam logic [FunW-1:0] AluPass = 6'b011010;
    // Shifts (B shifted by A[4:0])
    localparam logic [FunW-1:0] AluSll  = 6'b100000;
    localparam logic [FunW-1:0] AluSrl  = 6'b100001;
    localparam logic [FunW-1:0] AluSra  = 6'b100011;
    // Compares
    localparam logic [FunW-1:0] AluEq   = 6'b110011;
    localparam logic [FunW-1:0] AluNe   = 6'b110001;
    localparam logic [FunW-1:0] AluLt   = 6'b110101;
    localparam logic [FunW-1:0] AluLez  = 6'b111101;
    localparam logic [FunW-1:0] AluLtz  = 6'b111011;
    localparam logic [FunW-1:0] AluGtz  = 6'b111111;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } mul_state_e;

endpackage

// File: rtl/ex_stage_alu.sv
// alu: combinational ALUFun evaluator for the execute stage.
// Ports:
//   alufun_i  6-bit operation code
//   sign_i    LT compares signed when high, unsigned when low
//   a_i, b_i  32-bit operands
//   result_o  32-bit result (compares give 0/1, undefined codes give 0)
module alu
    import ex_pkg::*;
(
    input  logic [FunW-1:0]  alufun_i,
    input  logic             sign_i,
    input  logic [DataW-1:0] a_i,
    input  logic [DataW-1:0] b_i,
    output logic [DataW-1:0] result_o
);

    logic lt;
    logic a_zero;

    assign lt     = sign_i ? ($signed(a_i) < $signed(b_i)) : (a_i < b_i);
    assign a_zero = (a_i == '0);

    always_comb begin
        result_o = '0;
        case (alufun_i)
            // MUL shares the adder code path; ex_stage overrides it when the
            // multiplier is built in.
            AluAdd, AluMul: result_o = a_i + b_i;
            AluSub:  result_o = a_i - b_i;
            AluAnd:  result_o = a_i & b_i;
            AluOr:   result_o = a_i | b_i;
            AluXor:  result_o = a_i ^ b_i;
            AluNor:  result_o = ~(a_i | b_i);
            AluPass: result_o = a_i;
            AluSll:  result_o = b_i << a_i[4:0];
            AluSrl:  result_o = b_i >> a_i[4:0];
            AluSra:  result_o = $unsigned($signed(b_i) >>> a_i[4:0]);
            AluEq:   result_o = {31'b0, a_i == b_i};
            AluNe:   result_o = {31'b0, a_i != b_i};
            AluLt:   result_o = {31'b0, lt};
            AluLez:  result_o = {31'b0, a_i[31] | a_zero};
            AluLtz:  result_o = {31'b0, a_i[31]};
            AluGtz:  result_o = {31'b0, ~a_i[31] & ~a_zero};
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage plus EX/MEM pipeline register.
//   Forwards operands from MEM (priority) and WB, selects ALU sources, evaluates
//   ALUFun through the alu sub-module and registers results/controls for MEM.
// Ports:
//   clk, reset (async, active-low)
//   EX_*        ID/EX register outputs (operation, operands, register numbers, controls)
//   WB_*        write-back stage write port, used for forwarding
//   MEM_*       registered EX/MEM outputs
//   ex_stall    hold request to IF/ID and ID/EX
// Configuration:
//   EX_MUL_EN   adds a 32-iteration shift-add multiplier for ALUFun MUL; without it
//               MUL decodes as ADD and ex_stall is tied low.
module ex_stage
    import ex_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [FunW-1:0]  EX_ALUFun,
    input  logic             EX_Sign,
    input  logic             EX_ALUSrc1,
    input  logic             EX_ALUSrc2,
    input  logic             EX_EXTOp,
    input  logic             EX_LUOp,
    input  logic [DataW-1:0] EX_dataA,
    input  logic [DataW-1:0] EX_dataB,
    input  logic [ImmW-1:0]  EX_imm,
    input  logic [4:0]       EX_shamt,
    input  logic [RegW-1:0]  EX_rs,
    input  logic [RegW-1:0]  EX_rt,
    input  logic [RegW-1:0]  EX_WrReg,
    input  logic             EX_RegWr,
    input  logic             EX_MemWr,
    input  logic             EX_MemRd,
    input  logic [1:0]       EX_MemtoReg,
    input  logic             EXcontrol_jal,
    input  logic [DataW-1:0] EX_PC,
    input  logic             WB_RegWr,
    input  logic [RegW-1:0]  WB_WrReg,
    input  logic [DataW-1:0] WB_data,
    output logic [DataW-1:0] MEM_ALUOut,
    output logic [DataW-1:0] MEM_dataB,
    output logic [DataW-1:0] MEM_PC,
    output logic [RegW-1:0]  MEM_WrReg,
    output logic             MEM_RegWr,
    output logic             MEM_MemWr,
    output logic             MEM_MemRd,
    output logic [1:0]       MEM_MemtoReg,
    output logic             ex_stall
);

    logic [DataW-1:0] alu_out_q, data_b_q, pc_q;
    logic [RegW-1:0]  wr_reg_q;
    logic             reg_wr_q, mem_wr_q, mem_rd_q;
    logic [1:0]       memto_reg_q;

    logic [DataW-1:0] fwd_a, fwd_b, imm32, op_a, op_b, alu_res, ex_result;
    logic             stall_int;

    // Forwarding: MEM beats WB, and $0 is never forwarded.
    always_comb begin
        fwd_a = EX_dataA;
        if (reg_wr_q && (wr_reg_q == EX_rs) && (EX_rs != '0)) begin
            fwd_a = alu_out_q;
        end else if (WB_RegWr && (WB_WrReg == EX_rs) && (EX_rs != '0)) begin
            fwd_a = WB_data;
        end
    end

    always_comb begin
        fwd_b = EX_dataB;
        if (reg_wr_q && (wr_reg_q == EX_rt) && (EX_rt != '0)) begin
            fwd_b = alu_out_q;
        end else if (WB_RegWr && (WB_WrReg == EX_rt) && (EX_rt != '0)) begin
            fwd_b = WB_data;
        end
    end

    assign imm32 = EX_LUOp  ? {EX_imm, 16'h0000} :
                   EX_EXTOp ? {{16{EX_imm[15]}}, EX_imm} : {16'h0000, EX_imm};
    assign op_a  = EX_ALUSrc1 ? {27'b0, EX_shamt} : fwd_a;
    assign op_b  = EX_ALUSrc2 ? imm32 : fwd_b;

    alu u_alu (
        .alufun_i (EX_ALUFun),
        .sign_i   (EX_Sign),
        .a_i      (op_a),
        .b_i      (op_b),
        .result_o (alu_res)
    );

`ifdef EX_MUL_EN
    mul_state_e       state_q, state_d;
    logic [DataW-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             is_mul;

    assign is_mul = (EX_ALUFun == AluMul);

    // Stall covers the latch cycle and all BUSY cycles; DONE lets the product
    // through while the MUL is still held in ID/EX.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        stall_int = 1'b0;
        case (state_q)
            StIdle: begin
                if (is_mul) begin
                    stall_int = 1'b1;
                    acc_d     = '0;
                    mcand_d   = op_a;
                    mplier_d  = op_b;
                    cnt_d     = '0;
                    state_d   = StBusy;
                end
            end
            StBusy: begin
                stall_int = 1'b1;
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'(MulIters - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        ex_result = alu_res;
        if (EXcontrol_jal) begin
            ex_result = EX_PC + 32'd4;
        end else if (state_q == StDone) begin
            ex_result = acc_q;
        end
    end

    // Reset forces the hold request low even while a MUL sits in ID/EX.
    assign ex_stall = reset & stall_int;
`else
    assign stall_int = 1'b0;
    assign ex_result = EXcontrol_jal ? (EX_PC + 32'd4) : alu_res;
    assign ex_stall  = 1'b0;
`endif

    // EX/MEM register. A stall inserts a bubble: controls cleared, data held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_out_q   <= '0;
            data_b_q    <= '0;
            pc_q        <= RESET_PC;
            wr_reg_q    <= '0;
            reg_wr_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_rd_q    <= 1'b0;
            memto_reg_q <= '0;
        end else if (stall_int) begin
            reg_wr_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_rd_q    <= 1'b0;
        end else begin
            alu_out_q   <= ex_result;
            data_b_q    <= fwd_b;
            pc_q        <= EX_PC;
            wr_reg_q    <= EX_WrReg;
            reg_wr_q    <= EX_RegWr;
            mem_wr_q    <= EX_MemWr;
            mem_rd_q    <= EX_MemRd;
            memto_reg_q <= EX_MemtoReg;
        end
    end

    assign MEM_ALUOut   = alu_out_q;
    assign MEM_dataB    = data_b_q;
    assign MEM_PC       = pc_q;
    assign MEM_WrReg    = wr_reg_q;
    assign MEM_RegWr    = reg_wr_q;
    assign MEM_MemWr    = mem_wr_q;
    assign MEM_MemRd    = mem_rd_q;
    assign MEM_MemtoReg = memto_reg_q;

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;
    import ex_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  EX_ALUFun;
    logic        EX_Sign, EX_ALUSrc1, EX_ALUSrc2, EX_EXTOp, EX_LUOp;
    logic [31:0] EX_dataA, EX_dataB, EX_PC, WB_data;
    logic [15:0] EX_imm;
    logic [4:0]  EX_shamt, EX_rs, EX_rt, EX_WrReg, WB_WrReg;
    logic        EX_RegWr, EX_MemWr, EX_MemRd, EXcontrol_jal, WB_RegWr;
    logic [1:0]  EX_MemtoReg;
    logic [31:0] MEM_ALUOut, MEM_dataB, MEM_PC;
    logic [4:0]  MEM_WrReg;
    logic        MEM_RegWr, MEM_MemWr, MEM_MemRd;
    logic [1:0]  MEM_MemtoReg;
    logic        ex_stall;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ex_stage #(.RESET_PC(32'h8000_0000)) dut (
        .clk(clk), .reset(reset),
        .EX_ALUFun(EX_ALUFun), .EX_Sign(EX_Sign),
        .EX_ALUSrc1(EX_ALUSrc1), .EX_ALUSrc2(EX_ALUSrc2),
        .EX_EXTOp(EX_EXTOp), .EX_LUOp(EX_LUOp),
        .EX_dataA(EX_dataA), .EX_dataB(EX_dataB), .EX_imm(EX_imm), .EX_shamt(EX_shamt),
        .EX_rs(EX_rs), .EX_rt(EX_rt), .EX_WrReg(EX_WrReg),
        .EX_RegWr(EX_RegWr), .EX_MemWr(EX_MemWr), .EX_MemRd(EX_MemRd),
        .EX_MemtoReg(EX_MemtoReg), .EXcontrol_jal(EXcontrol_jal), .EX_PC(EX_PC),
        .WB_RegWr(WB_RegWr), .WB_WrReg(WB_WrReg), .WB_data(WB_data),
        .MEM_ALUOut(MEM_ALUOut), .MEM_dataB(MEM_dataB), .MEM_PC(MEM_PC),
        .MEM_WrReg(MEM_WrReg), .MEM_RegWr(MEM_RegWr), .MEM_MemWr(MEM_MemWr),
        .MEM_MemRd(MEM_MemRd), .MEM_MemtoReg(MEM_MemtoReg), .ex_stall(ex_stall)
    );

    task automatic clear_inputs();
        EX_ALUFun = AluAdd; EX_Sign = 1'b0; EX_ALUSrc1 = 1'b0; EX_ALUSrc2 = 1'b0;
        EX_EXTOp = 1'b0; EX_LUOp = 1'b0; EX_dataA = '0; EX_dataB = '0; EX_imm = '0;
        EX_shamt = '0; EX_rs = '0; EX_rt = '0; EX_WrReg = '0; EX_RegWr = 1'b0;
        EX_MemWr = 1'b0; EX_MemRd = 1'b0; EX_MemtoReg = '0; EXcontrol_jal = 1'b0;
        EX_PC = '0; WB_RegWr = 1'b0; WB_WrReg = '0; WB_data = '0;
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        step();
        step();
        checks++;
        if (MEM_PC !== 32'h8000_0000 || MEM_ALUOut !== 32'h0 || MEM_WrReg !== 5'd0) begin
            errors++;
            $display("FAIL reset_data: PC=%h ALUOut=%h WrReg=%0d, want 80000000/0/0",
                     MEM_PC, MEM_ALUOut, MEM_WrReg);
        end
        checks++;
        if ({MEM_RegWr, MEM_MemWr, MEM_MemRd, MEM_MemtoReg, ex_stall} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {MEM_RegWr, MEM_MemWr, MEM_MemRd, MEM_MemtoReg, ex_stall});
        end
        reset = 1'b1;
        #1;
        checks++;
        if (MEM_PC !== 32'h8000_0000) begin
            errors++;
            $display("FAIL reset_release: PC=%h want 80000000", MEM_PC);
        end
    endtask

    task automatic test_forward();
        // Prime MEM with r5 = 7.
        clear_inputs();
        EX_rs = 5'd1; EX_dataA = 32'd7; EX_WrReg = 5'd5; EX_RegWr = 1'b1;
        step();
        // MEM and WB both hit r5; MEM must win. B = 3 from the register file.
        EX_rs = 5'd5; EX_dataA = 32'd100; EX_rt = 5'd6; EX_dataB = 32'd3;
        WB_RegWr = 1'b1; WB_WrReg = 5'd5; WB_data = 32'd9; EX_WrReg = 5'd10;
        step();
        checks++;
        if (MEM_ALUOut !== 32'd10) begin
            errors++;
            $display("FAIL add_fwd_mem: got %h want %h", MEM_ALUOut, 32'd10);
        end
        // MEM now holds r10=10; WB forwards r5=9 to A.
        EX_WrReg = 5'd11; EX_rt = 5'd0; EX_dataB = 32'd1;
        step();
        checks++;
        if (MEM_ALUOut !== 32'd10) begin
            errors++;
            $display("FAIL add_fwd_wb: got %h want %h", MEM_ALUOut, 32'd10);
        end
        // Store: B from WB (r8) becomes store data; controls pass through.
        clear_inputs();
        EX_rt = 5'd8; EX_dataB = 32'h1111_1111; WB_RegWr = 1'b1; WB_WrReg = 5'd8;
        WB_data = 32'hCAFE_0001; EX_MemWr = 1'b1; EX_MemtoReg = 2'b10; EX_MemRd = 1'b1;
        step();
        checks++;
        if (MEM_dataB !== 32'hCAFE_0001 || MEM_MemWr !== 1'b1 || MEM_MemRd !== 1'b1 ||
            MEM_MemtoReg !== 2'b10 || MEM_RegWr !== 1'b0) begin
            errors++;
            $display("FAIL store_fwd_b: dataB=%h MemWr=%b MemRd=%b MtoR=%b RegWr=%b", MEM_dataB,
                     MEM_MemWr, MEM_MemRd, MEM_MemtoReg, MEM_RegWr);
        end
    endtask

    task automatic test_zero_guard();
        clear_inputs();
        EX_rs = 5'd1; EX_dataA = 32'hFFFF_FFFF; EX_WrReg = 5'd0; EX_RegWr = 1'b1;
        step();
        EX_rs = 5'd0; EX_dataA = 32'h11; EX_rt = 5'd0; EX_dataB = 32'h22;
        WB_RegWr = 1'b1; WB_WrReg = 5'd0; WB_data = 32'h1000; EX_RegWr = 1'b0;
        step();
        checks++;
        if (MEM_ALUOut !== 32'h33) begin
            errors++;
            $display("FAIL zero_guard: got %h want %h", MEM_ALUOut, 32'h33);
        end
    endtask

    task automatic test_logic_arith();
        logic [5:0]  fun [7] = '{AluAnd, AluOr, AluXor, AluNor, AluPass, AluSub, AluSub};
        logic [31:0] av  [7] = '{32'hF0F0_1234, 32'hF0F0_1234, 32'hF0F0_1234, 32'hF0F0_1234,
                                 32'hF0F0_1234, 32'd10, 32'd0};
        logic [31:0] bv  [7] = '{32'h0FF0_00FF, 32'h0FF0_00FF, 32'h0FF0_00FF, 32'h0FF0_00FF,
                                 32'h0FF0_00FF, 32'd3, 32'd1};
        logic [31:0] exp [7] = '{32'h00F0_0034, 32'hFFF0_12FF, 32'hFF00_12CB, 32'h000F_ED00,
                                 32'hF0F0_1234, 32'd7, 32'hFFFF_FFFF};
        clear_inputs();
        for (int i = 0; i < 7; i++) begin
            EX_ALUFun = fun[i]; EX_dataA = av[i]; EX_dataB = bv[i];
            step();
            checks++;
            if (MEM_ALUOut !== exp[i]) begin
                errors++;
                $display("FAIL logic_arith[%0d] fun=%b: got %h want %h", i, fun[i], MEM_ALUOut,
                         exp[i]);
            end
        end
    endtask

    task automatic test_immediate();
        logic [2:0]  sel [3] = '{3'b010, 3'b000, 3'b001};  // {EXTOp, LUOp} packed as {_,EXT,LU}
        logic [31:0] exp [3] = '{32'hFFFF_8002, 32'h0000_8002, 32'h8001_0001};
        clear_inputs();
        EX_ALUSrc2 = 1'b1; EX_imm = 16'h8001; EX_dataA = 32'd1;
        EX_rt = 5'd3; EX_dataB = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            EX_EXTOp = sel[i][1]; EX_LUOp = sel[i][0];
            step();
            checks++;
            if (MEM_ALUOut !== exp[i]) begin
                errors++;
                $display("FAIL imm[%0d]: got %h want %h", i, MEM_ALUOut, exp[i]);
            end
        end
    endtask

    task automatic test_compare_shift();
        logic [5:0]  fun [16] = '{AluEq, AluEq, AluNe, AluLt, AluLt, AluLez, AluLez, AluLtz,
                                  AluGtz, AluGtz, AluGtz, 6'b111000, AluSll, AluSrl, AluSra,
                                  AluSll};
        logic        sgn [16] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        logic        sh  [16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0};
        logic [31:0] av  [16] = '{32'd5, 32'd5, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,
                                  32'd1, 32'h8000_0000, 32'd0, 32'd3, 32'hFFFF_FFFF, 32'd7,
                                  32'd0, 32'd0, 32'd0, 32'h21};
        logic [31:0] bv  [16] = '{32'd5, 32'd6, 32'd6, 32'd1, 32'd1, 32'd0, 32'd0, 32'd0,
                                  32'd0, 32'd0, 32'd0, 32'd9, 32'd1, 32'h8000_0000,
                                  32'h8000_0000, 32'd3};
        logic [31:0] exp [16] = '{32'd1, 32'd0, 32'd1, 32'd1, 32'd0, 32'd1, 32'd0, 32'd1,
                                  32'd0, 32'd1, 32'd0, 32'd0, 32'h10, 32'h0800_0000,
                                  32'hF800_0000, 32'd6};
        clear_inputs();
        EX_shamt = 5'd4;
        for (int i = 0; i < 16; i++) begin
            EX_ALUFun = fun[i]; EX_Sign = sgn[i]; EX_ALUSrc1 = sh[i];
            EX_dataA = av[i]; EX_dataB = bv[i];
            step();
            checks++;
            if (MEM_ALUOut !== exp[i]) begin
                errors++;
                $display("FAIL cmp_shift[%0d] fun=%b: got %h want %h", i, fun[i], MEM_ALUOut,
                         exp[i]);
            end
        end
    endtask

    task automatic test_jal();
        clear_inputs();
        EXcontrol_jal = 1'b1; EX_PC = 32'h0040_0010; EX_WrReg = 5'd31; EX_RegWr = 1'b1;
        EX_dataA = 32'h1234; EX_dataB = 32'h1;
        step();
        checks++;
        if (MEM_ALUOut !== 32'h0040_0014 || MEM_WrReg !== 5'd31 || MEM_RegWr !== 1'b1 ||
            MEM_PC !== 32'h0040_0010) begin
            errors++;
            $display("FAIL jal: ALUOut=%h WrReg=%0d RegWr=%b PC=%h want 00400014/31/1/00400010",
                     MEM_ALUOut, MEM_WrReg, MEM_RegWr, MEM_PC);
        end
    endtask

    task automatic test_async_reset();
        clear_inputs();
        EX_RegWr = 1'b1; EX_MemWr = 1'b1; EX_WrReg = 5'd4; EX_PC = 32'h10;
        step();
        #2 reset = 1'b0;
        #1;
        checks++;
        if (MEM_RegWr !== 1'b0 || MEM_MemWr !== 1'b0 || MEM_PC !== 32'h8000_0000 ||
            MEM_WrReg !== 5'd0) begin
            errors++;
            $display("FAIL async_reset: RegWr=%b MemWr=%b PC=%h WrReg=%0d", MEM_RegWr,
                     MEM_MemWr, MEM_PC, MEM_WrReg);
        end
        clear_inputs();
        step();
        reset = 1'b1;
    endtask

`ifdef EX_MUL_EN
    task automatic test_mul();
        int stall_cycles;
        clear_inputs();
        EX_ALUFun = AluMul; EX_dataA = 32'h0001_0003; EX_dataB = 32'h0000_0005;
        EX_RegWr = 1'b1; EX_WrReg = 5'd9; EX_PC = 32'h0000_0100;
        #1;
        stall_cycles = 0;
        for (int i = 0; i < 40 && ex_stall === 1'b1; i++) begin
            stall_cycles++;
            step();
            checks++;
            if (MEM_RegWr !== 1'b0) begin
                errors++;
                $display("FAIL mul_bubble[%0d]: RegWr=%b want 0", i, MEM_RegWr);
            end
        end
        checks++;
        if (stall_cycles != 33) begin
            errors++;
            $display("FAIL mul_stall_len: got %0d want 33", stall_cycles);
        end
        step();
        checks++;
        if (MEM_ALUOut !== 32'h0005_000F || MEM_RegWr !== 1'b1 || MEM_WrReg !== 5'd9) begin
            errors++;
            $display("FAIL mul_result: ALUOut=%h RegWr=%b WrReg=%0d want 0005000f/1/9",
                     MEM_ALUOut, MEM_RegWr, MEM_WrReg);
        end
        // Back-to-back MUL restarts from IDLE and stalls again.
        checks++;
        if (ex_stall !== 1'b1) begin
            errors++;
            $display("FAIL mul_b2b_stall: got %b want 1", ex_stall);
        end
        for (int i = 0; i < 5; i++) step();
        #2 reset = 1'b0;
        #1;
        checks++;
        if (ex_stall !== 1'b0 || MEM_RegWr !== 1'b0) begin
            errors++;
            $display("FAIL mul_reset: stall=%b RegWr=%b want 0/0", ex_stall, MEM_RegWr);
        end
        clear_inputs();
        EX_dataA = 32'd2; EX_dataB = 32'd2;
        step();
        reset = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            checks++;
            if (ex_stall !== 1'b0 || MEM_RegWr !== 1'b0) begin
                errors++;
                $display("FAIL mul_abort[%0d]: stall=%b RegWr=%b want 0/0", i, ex_stall,
                         MEM_RegWr);
            end
        end
        checks++;
        if (MEM_ALUOut !== 32'd4) begin
            errors++;
            $display("FAIL mul_after_reset: got %h want 4", MEM_ALUOut);
        end
    endtask
`else
    task automatic test_mul();
        clear_inputs();
        EX_ALUFun = AluMul; EX_dataA = 32'd2; EX_dataB = 32'd3; EX_RegWr = 1'b1;
        #1;
        checks++;
        if (ex_stall !== 1'b0) begin
            errors++;
            $display("FAIL mul_nostall: got %b want 0", ex_stall);
        end
        step();
        checks++;
        if (MEM_ALUOut !== 32'd5 || MEM_RegWr !== 1'b1) begin
            errors++;
            $display("FAIL mul_as_add: ALUOut=%h RegWr=%b want 5/1", MEM_ALUOut, MEM_RegWr);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_forward();
        test_zero_guard();
        test_logic_arith();
        test_immediate();
        test_compare_shift();
        test_jal();
        test_async_reset();
        test_mul();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
